// File: rtl/alu_sequencer.sv
// Request/response sequencer that drives an external ALU through a fixed
// issue/capture cycle and returns one registered response per request.
module alu_sequencer #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [N-1:0] req_a,
   input  logic [N-1:0] req_b,
   input  logic [2:0]   req_op,
   output logic [N-1:0] alu_a,
   output logic [N-1:0] alu_b,
   output logic [2:0]   alu_op,
   output logic         alu_op_sum,
   output logic         alu_op_subt,
   input  logic [N-1:0] alu_result,
   input  logic         alu_carry,
   output logic         resp_valid,
   input  logic         resp_ready,
   output logic [N-1:0] resp_result,
   output logic         resp_carry,
   output logic         resp_zero,
   output logic         resp_err,
   output logic [7:0]   op_count
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ISSUE   = 2'd1;
   localparam logic [1:0] ST_CAPTURE = 2'd2;
   localparam logic [1:0] ST_RESP    = 2'd3;

   localparam logic [2:0] OP_ADD      = 3'b000;
   localparam logic [2:0] OP_SUB      = 3'b001;
   localparam logic [2:0] OP_RESERVED = 3'b111;

   logic [1:0]   r_state;
   logic [N-1:0] r_a;
   logic [N-1:0] r_b;
   logic [2:0]   r_op;
   logic         r_sum;
   logic         r_subt;
   logic [N-1:0] r_result;
   logic         r_carry;
   logic         r_zero;
   logic         r_err;
   logic [7:0]   r_count;

   logic         w_accept;
   logic         w_handshake;
   logic         w_reserved;

   // Accept is qualified by the state register, so a response handshake
   // (which happens in RESP) can never coincide with a new accept.
   assign w_accept    = req_valid && (r_state == ST_IDLE);
   assign w_handshake = resp_ready && (r_state == ST_RESP);
   assign w_reserved  = (req_op == OP_RESERVED);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state <= w_reserved ? ST_RESP : ST_ISSUE;
               end
            end
            ST_ISSUE:   r_state <= ST_CAPTURE;
            ST_CAPTURE: r_state <= ST_RESP;
            ST_RESP: begin
               if (resp_ready) begin
                  r_state <= ST_IDLE;
               end
            end
            default:    r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a  <= '0;
         r_b  <= '0;
         r_op <= '0;
      end else if (w_accept) begin
         r_a  <= req_a;
         r_b  <= req_b;
         r_op <= req_op;
      end
   end

   // Strobes are registered so they span exactly ISSUE and CAPTURE without
   // decode glitches on the ALU side.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sum  <= 1'b0;
         r_subt <= 1'b0;
      end else if (w_accept) begin
         r_sum  <= (req_op == OP_ADD);
         r_subt <= (req_op == OP_SUB);
      end else if (r_state == ST_CAPTURE) begin
         r_sum  <= 1'b0;
         r_subt <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_result <= '0;
         r_carry  <= 1'b0;
         r_zero   <= 1'b0;
         r_err    <= 1'b0;
      end else if (w_accept && w_reserved) begin
         r_result <= '0;
         r_carry  <= 1'b0;
         r_zero   <= 1'b0;
         r_err    <= 1'b1;
      end else if (r_state == ST_CAPTURE) begin
         r_result <= alu_result;
         r_carry  <= alu_carry;
         r_zero   <= (alu_result == '0);
         r_err    <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= 8'd0;
      end else if (w_handshake && !r_err) begin
         r_count <= r_count + 8'd1;
      end
   end

   assign req_ready   = (r_state == ST_IDLE) && !rst;
   assign resp_valid  = (r_state == ST_RESP);
   assign alu_a       = r_a;
   assign alu_b       = r_b;
   assign alu_op      = r_op;
   assign alu_op_sum  = r_sum;
   assign alu_op_subt = r_subt;
   assign resp_result = r_result;
   assign resp_carry  = r_carry;
   assign resp_zero   = r_zero;
   assign resp_err    = r_err;
   assign op_count    = r_count;

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomised self-checking bench for alu_sequencer with a behavioural 4-bit
// ALU attached and an arithmetic reference model of the expected responses.
module tb_alu_sequencer;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req_valid;
   logic         req_ready;
   logic [N-1:0] req_a;
   logic [N-1:0] req_b;
   logic [2:0]   req_op;
   logic [N-1:0] alu_a;
   logic [N-1:0] alu_b;
   logic [2:0]   alu_op;
   logic         alu_op_sum;
   logic         alu_op_subt;
   logic [N-1:0] alu_result;
   logic         alu_carry;
   logic         resp_valid;
   logic         resp_ready;
   logic [N-1:0] resp_result;
   logic         resp_carry;
   logic         resp_zero;
   logic         resp_err;
   logic [7:0]   op_count;

   int checkCount = 0;
   int errorCount = 0;
   int modelOpCount = 0;

   alu_sequencer #(.N(N)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_op_sum(alu_op_sum), .alu_op_subt(alu_op_subt),
      .alu_result(alu_result), .alu_carry(alu_carry),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_result(resp_result), .resp_carry(resp_carry),
      .resp_zero(resp_zero), .resp_err(resp_err),
      .op_count(op_count)
   );

   always #5 clk = ~clk;

   // Behavioural ALU the sequencer talks to; shifts use b[1:0] as amount.
   always_comb begin
      alu_result = '0;
      alu_carry  = 1'b0;
      case (alu_op)
         3'd0: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
         3'd1: begin
            alu_result = alu_a - alu_b;
            alu_carry  = (alu_a < alu_b);
         end
         3'd2: alu_result = alu_a & alu_b;
         3'd3: alu_result = alu_a | alu_b;
         3'd4: alu_result = alu_a ^ alu_b;
         3'd5: alu_result = alu_a << alu_b[1:0];
         3'd6: alu_result = alu_a >> alu_b[1:0];
         default: alu_result = '0;
      endcase
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed != expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Expected response computed with plain integer arithmetic.
   function automatic void refModel(input int a, input int b, input int op,
                                    output int res, output int carry, output int err);
      int t;
      res = 0; carry = 0; err = 0;
      case (op)
         0: begin t = a + b; res = t % 16; carry = t / 16; end
         1: begin t = a - b; res = (t + 16) % 16; carry = (a < b) ? 1 : 0; end
         2: res = a & b;
         3: res = a | b;
         4: res = a ^ b;
         5: res = (a * (1 << (b % 4))) % 16;
         6: res = a / (1 << (b % 4));
         default: err = 1;
      endcase
   endfunction

   // One complete request/response; holdCycles keeps resp_ready low in RESP
   // while a competing request is presented.
   task automatic applyStimulus(input int a, input int b, input int op, input int holdCycles);
      int expRes, expCarry, expErr, expZero;
      int edges, sumCycles, subtCycles, waitCount;
      refModel(a, b, op, expRes, expCarry, expErr);
      expZero = (expErr == 0 && expRes == 0) ? 1 : 0;
      waitCount = 0;
      while (!req_ready && waitCount < 20) begin
         @(posedge clk); #1;
         waitCount++;
      end
      checkOutput("reqReadyIdle", int'(req_ready), 1);
      req_a = 4'(a); req_b = 4'(b); req_op = 3'(op);
      req_valid = 1'b1;
      resp_ready = (holdCycles == 0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_a = 4'($urandom_range(0, 15));
      req_b = 4'($urandom_range(0, 15));
      req_op = 3'($urandom_range(0, 7));
      edges = 1; sumCycles = 0; subtCycles = 0;
      while (!resp_valid && edges < 10) begin
         sumCycles += int'(alu_op_sum);
         subtCycles += int'(alu_op_subt);
         checkOutput("reqReadyBusy", int'(req_ready), 0);
         @(posedge clk); #1;
         edges++;
      end
      checkOutput("latency", edges, (op == 7) ? 1 : 3);
      checkOutput("sumCycles", sumCycles, (op == 0) ? 2 : 0);
      checkOutput("subtCycles", subtCycles, (op == 1) ? 2 : 0);
      checkOutput("strobesInResp", int'(alu_op_sum | alu_op_subt), 0);
      checkOutput("result", int'(resp_result), expRes);
      checkOutput("carry", int'(resp_carry), expCarry);
      checkOutput("zero", int'(resp_zero), expZero);
      checkOutput("err", int'(resp_err), expErr);
      checkOutput("aluA", int'(alu_a), a);
      checkOutput("aluB", int'(alu_b), b);
      checkOutput("aluOp", int'(alu_op), op);
      for (int i = 0; i < holdCycles; i++) begin
         req_valid = 1'b1;
         req_a = 4'($urandom_range(0, 15));
         req_b = 4'($urandom_range(0, 15));
         req_op = 3'($urandom_range(0, 6));
         @(posedge clk); #1;
         checkOutput("holdValid", int'(resp_valid), 1);
         checkOutput("holdReqReady", int'(req_ready), 0);
         checkOutput("holdResult", int'(resp_result), expRes);
         checkOutput("holdErr", int'(resp_err), expErr);
         checkOutput("holdAluA", int'(alu_a), a);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      req_valid = 1'b0;
      if (expErr == 0) modelOpCount = (modelOpCount + 1) % 256;
      checkOutput("opCount", int'(op_count), modelOpCount);
      checkOutput("respValidAfter", int'(resp_valid), 0);
      checkOutput("reqReadyAfter", int'(req_ready), 1);
   endtask

   initial begin
      req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; resp_ready = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rstRespValid", int'(resp_valid), 0);
      checkOutput("rstOpCount", int'(op_count), 0);
      checkOutput("rstAluA", int'(alu_a), 0);
      checkOutput("rstSum", int'(alu_op_sum), 0);
      checkOutput("rstErr", int'(resp_err), 0);
      @(negedge clk) rst = 1'b0;
      #1;
      checkOutput("rstReqReady", int'(req_ready), 1);

      applyStimulus(9, 8, 0, 0);
      applyStimulus(5, 5, 1, 0);
      applyStimulus(3, 4, 7, 0);
      applyStimulus(6, 2, 0, 5);
      applyStimulus(12, 3, 2, 0);
      applyStimulus(2, 9, 1, 2);

      // Abort an add while it sits in CAPTURE.
      req_a = 4'd7; req_b = 4'd1; req_op = 3'd0; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      checkOutput("midOpSum", int'(alu_op_sum), 1);
      rst = 1'b1;
      #1;
      modelOpCount = 0;
      checkOutput("midRstRespValid", int'(resp_valid), 0);
      checkOutput("midRstOpCount", int'(op_count), 0);
      checkOutput("midRstSum", int'(alu_op_sum), 0);
      @(negedge clk) rst = 1'b0;
      #1;
      checkOutput("midRstReqReady", int'(req_ready), 1);

      // Back-to-back valid ops from a zero count must wrap to zero.
      for (int i = 0; i < 256; i++) begin
         applyStimulus($urandom_range(0, 15), $urandom_range(0, 15),
                       $urandom_range(0, 6), $urandom_range(0, 1));
      end
      checkOutput("wrapOpCount", int'(op_count), 0);

      for (int i = 0; i < 20; i++) begin
         applyStimulus($urandom_range(0, 15), $urandom_range(0, 15),
                       $urandom_range(0, 7), $urandom_range(0, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: N, default 4, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  sequencer can accept a request.
REQ-006 req_a, req_b  input  N each  operands.
REQ-007 req_op  input  3  opcode: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shl, 110 shr, 111 reserved.
REQ-008 alu_a, alu_b  output  N each  operands driven to the ALU.
REQ-009 alu_op  output  3  opcode driven to the ALU.
REQ-010 alu_op_sum, alu_op_subt  output  1 each  add/subtract strobes to the ALU.
REQ-011 alu_result  input  N  ALU result; alu_carry  input  1  ALU carry/borrow.
REQ-012 resp_valid  output  1  response present; resp_ready  input  1  consumer accepts.
REQ-013 resp_result  output  N; resp_carry, resp_zero, resp_err  output  1 each.
REQ-014 op_count  output  8  completed non-error operations, wrapping.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, CAPTURE, RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 Accept = req_valid & req_ready at a rising edge; req_a, req_b, req_op SHALL be latched into internal registers at that edge.
REQ-017 IDLE: on accept with op != 111 go to ISSUE; on accept with op = 111 go to RESP with resp_err=1, resp_result=0, resp_carry=0, resp_zero=0; else stay.
REQ-018 ISSUE: ALU inputs settle for one full cycle; unconditionally go to CAPTURE.
REQ-019 CAPTURE: at the exiting edge, register resp_result=alu_result, resp_carry=alu_carry, resp_zero=(alu_result==0), resp_err=0; go to RESP.
REQ-020 RESP: resp_valid=1; response registers SHALL hold stable until resp_valid & resp_ready, then go to IDLE.
REQ-021 Latency: resp_valid SHALL rise 3 edges after the accept edge for valid ops, 1 edge for op 111.
REQ-022 A request SHALL NOT be accepted in the same cycle a response handshakes; earliest next accept is the cycle after return to IDLE.
REQ-023 alu_a, alu_b, alu_op SHALL always reflect the latched registers (registered, glitch-free).
REQ-024 alu_op_sum SHALL be 1 only in ISSUE/CAPTURE with latched op=000; alu_op_subt only in ISSUE/CAPTURE with latched op=001; both 0 otherwise.
REQ-025 op_count SHALL increment by 1 on each response handshake with resp_err=0; 255 wraps to 0; error responses do not count.
REQ-026 Changes on req_* while not in IDLE SHALL be ignored.

Reset
REQ-027 rst high SHALL immediately (asynchronously) force state IDLE and all registers/outputs to 0 except req_ready=1 (once rst is low); resp_valid=0, op_count=0.
REQ-028 Reset asserted in ISSUE, CAPTURE, or RESP SHALL abort the operation with no response produced and no op_count change.
REQ-029 First accept SHALL be possible at the first rising edge after rst deasserts.

Verification (bench connects a behavioural N=4 ALU: add/sub mod 16 with carry-out/borrow)
REQ-030 add: a=9, b=8, op=000, resp_ready=1 -> resp_valid 3 edges after accept, result=1, carry=1, zero=0, op_count=1; alu_op_sum high exactly 2 cycles.
REQ-031 sub: a=5, b=5, op=001 -> result=0, zero=1, carry per model, alu_op_subt high 2 cycles, alu_op_sum stays 0.
REQ-032 reserved: op=111 -> resp_valid 1 edge after accept, err=1, result=0, alu strobes never high, op_count unchanged.
REQ-033 backpressure: resp_ready=0 for 5 cycles during RESP with req_valid=1 and new operands -> response stable, req_ready=0, no new accept; after handshake, next request accepted one cycle later.
REQ-034 reset mid-op: rst pulsed in CAPTURE -> resp_valid=0, req_ready=1 after release, op_count=0, no response emitted.
REQ-035 wrap: 256 back-to-back valid ops -> op_count returns to 0; zero flag correct on every response.
